if_id_stage: RTL

//  Instruction-fetch stage plus IF/ID pipeline register of the RV32I pipeline.

---
 rtl/if_id_stage.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
//   Instruction-fetch stage and IF/ID pipeline register of the RV32I pipeline.
//   Owns the PC, requests instructions from a variable-latency instruction
//   memory and presents {pc_o, instr_o, valid_o} to decode. Honours load-use
//   stall and branch flush. A one-entry hold buffer keeps a word returned
//   while decode is stalled so that it is not lost.
//
// Parameters
//   RESET_PC         PC loaded on reset
//   NOP              bubble instruction (addi x0,x0,0)
//
// Ports
//   clk_i            clock, all state updates on posedge
//   rst_i            asynchronous active-low reset
//   start_i          level; fetching begins the cycle after it is first seen
//   stall_i          hold IF/ID and PC (load-use hazard)
//   flush_i          branch taken: redirect PC to branch_target_i, squash IF/ID
//   branch_target_i  redirect address, bits [1:0] forced to zero
//   imem_req_o       fetch request
//   imem_addr_o      fetch address (current PC)
//   imem_rdata_i     instruction word for imem_addr_o
//   imem_valid_i     imem_rdata_i is valid this cycle
//   pc_o             PC of the instruction held in IF/ID
//   instr_o          instruction held in IF/ID
//   valid_o          IF/ID holds a real instruction
// ---------------------------------------------------------------------------
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_valid_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP;
            ifid_valid_q <= 1'b0;
            buf_pc_q     <= '0;
            buf_instr_q  <= NOP;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            buf_pc_q     <= buf_pc_d;
            buf_instr_q  <= buf_instr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        buf_pc_d     = buf_pc_q;
        buf_instr_d  = buf_instr_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = FETCH;
                end
            end

            FETCH: begin
                if (flush_i) begin
                    // Flush beats stall; any word returning this cycle is dropped.
                    pc_d         = branch_target_i & ~32'h3;
                    ifid_pc_d    = '0;
                    ifid_instr_d = NOP;
                    ifid_valid_d = 1'b0;
                end else if (stall_i) begin
                    // Park the returned word; decode still owns IF/ID.
                    if (imem_valid_i) begin
                        buf_pc_d    = pc_q;
                        buf_instr_d = imem_rdata_i;
                        pc_d        = pc_q + 32'd4;
                        state_d     = HOLD;
                    end
                end else if (imem_valid_i) begin
                    ifid_pc_d    = pc_q;
                    ifid_instr_d = imem_rdata_i;
                    ifid_valid_d = 1'b1;
                    pc_d         = pc_q + 32'd4;
                end else begin
                    ifid_pc_d    = '0;
                    ifid_instr_d = NOP;
                    ifid_valid_d = 1'b0;
                end
            end

            HOLD: begin
                if (flush_i) begin
                    pc_d         = branch_target_i & ~32'h3;
                    ifid_pc_d    = '0;
                    ifid_instr_d = NOP;
                    ifid_valid_d = 1'b0;
                    state_d      = FETCH;
                end else if (!stall_i) begin
                    ifid_pc_d    = buf_pc_q;
                    ifid_instr_d = buf_instr_q;
                    ifid_valid_d = 1'b1;
                    state_d      = FETCH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_req_o  = (state_q == FETCH);
    assign imem_addr_o = pc_q;
    assign pc_o        = ifid_pc_q;
    assign instr_o     = ifid_instr_q;
    assign valid_o     = ifid_valid_q;

endmodule
